// File: rtl/modexp_ctrl_pkg.sv
// Shared definitions for the modular-exponentiation sequencer.
// State encodings and op_sel codes are also used by the datapath.
package modexp_ctrl_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_LOAD      = 3'd1;
  localparam logic [2:0] ST_SQ_START  = 3'd2;
  localparam logic [2:0] ST_SQ_WAIT   = 3'd3;
  localparam logic [2:0] ST_MUL_START = 3'd4;
  localparam logic [2:0] ST_MUL_WAIT  = 3'd5;
  localparam logic [2:0] ST_NEXT      = 3'd6;
  localparam logic [2:0] ST_DONE      = 3'd7;

  typedef enum logic [2:0] {
    IDLE      = ST_IDLE,
    LOAD      = ST_LOAD,
    SQ_START  = ST_SQ_START,
    SQ_WAIT   = ST_SQ_WAIT,
    MUL_START = ST_MUL_START,
    MUL_WAIT  = ST_MUL_WAIT,
    NEXT      = ST_NEXT,
    DONE      = ST_DONE
  } state_t;

  localparam logic OP_SQUARE = 1'b0;
  localparam logic OP_MULT   = 1'b1;

  function automatic logic is_wait(input state_t s);
    return (s == SQ_WAIT) || (s == MUL_WAIT);
  endfunction

endpackage

// File: rtl/modexp_watchdog.sv
// Per-operation watchdog: counts cycles spent waiting for op_done.
// expired is high once the count has reached TIMEOUT.
module modexp_watchdog #(
  parameter int TIMEOUT = 1023
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] count;

  // Clear on wait-state entry, count up while waiting, saturate at limit
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && count != LIMIT) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer for the modexp datapath.
// Registered Moore outputs, bit-index down-counter, watchdog and abort.
module modexp_ctrl
  import modexp_ctrl_pkg::*;
#(
  parameter int EXP_W   = 16,
  parameter int TIMEOUT = 1023,
  localparam int IDX_W  = (EXP_W > 1) ? $clog2(EXP_W) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic             abort,
  input  logic             exp_bit,
  input  logic             op_done,
  output logic             load,
  output logic             op_start,
  output logic             op_sel,
  output logic [IDX_W-1:0] bit_idx,
  output logic             running,
  output logic             done,
  output logic             err
);

  state_t state;
  state_t nxt;
  logic   err_n;
  logic   in_wait;
  logic   wd_clear;
  logic   wd_enable;
  logic   wd_expired;

  assign in_wait   = is_wait(state);
  assign wd_clear  = (state == SQ_START) || (state == MUL_START);
  assign wd_enable = in_wait && !op_done;

  modexp_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wd (
    .clk    (clk),
    .reset  (reset),
    .clear  (wd_clear),
    .enable (wd_enable),
    .expired(wd_expired)
  );

  // Next-state decode; abort outranks watchdog, which outranks op_done
  always_comb begin
    nxt   = state;
    err_n = 1'b0;
    unique case (state)
      IDLE:      if (go) nxt = LOAD;
      LOAD:      nxt = SQ_START;
      SQ_START:  nxt = SQ_WAIT;
      SQ_WAIT:   if (op_done) nxt = exp_bit ? MUL_START : NEXT;
      MUL_START: nxt = MUL_WAIT;
      MUL_WAIT:  if (op_done) nxt = NEXT;
      NEXT:      nxt = (bit_idx == '0) ? DONE : SQ_START;
      DONE:      nxt = IDLE;
      default:   nxt = IDLE;
    endcase
    if (in_wait && !op_done && wd_expired) begin
      nxt   = IDLE;
      err_n = 1'b1;
    end
    if (state != IDLE && abort) begin
      nxt   = IDLE;
      err_n = 1'b1;
    end
  end

  // State, bit index and outputs all registered from the next state
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      bit_idx  <= '0;
      load     <= 1'b0;
      op_start <= 1'b0;
      op_sel   <= OP_SQUARE;
      running  <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state <= nxt;
      if (state == IDLE && nxt == LOAD) begin
        bit_idx <= IDX_W'(EXP_W - 1);
      end else if (state == NEXT && nxt == SQ_START) begin
        bit_idx <= bit_idx - IDX_W'(1);
      end
      load     <= (nxt == LOAD);
      op_start <= (nxt == SQ_START) || (nxt == MUL_START);
      op_sel   <= (nxt == MUL_START || nxt == MUL_WAIT)
                  ? OP_MULT : OP_SQUARE;
      running  <= (nxt != IDLE) && (nxt != DONE);
      done     <= (nxt == DONE);
      err      <= err_n;
    end
  end

endmodule

// File: doc/modexp_ctrl.md
# modexp_ctrl

Parametrised sequencer for the RSA modular-exponentiation datapath. It generalises the team's go/over idle–run–done control unit from a single wait-for-over phase to a full left-to-right square-and-multiply schedule over an EXP_W-bit exponent. It issues one square per exponent bit and one extra multiply per set bit. It adds a per-operation watchdog and an abort path. It sits between the RFID command layer (go/abort/done) and the modular-multiplier datapath (op_start/op_sel/op_done).

## Interface
- EXP_W, 16: exponent width in bits; must be ≥ 1.
- TIMEOUT, 1023: maximum cycles spent in any wait state before error; must be ≥ 1.
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset; low at a rising edge forces the reset state.
- go  in  1  start request; sampled only in IDLE.
- abort  in  1  cancel the current run; sampled in every non-IDLE state.
- exp_bit  in  1  exponent bit at index bit_idx, supplied by the datapath.
- op_done  in  1  datapath finished the current square or multiply; sampled only in SQ_WAIT/MUL_WAIT.
- load  out  1  one-cycle pulse: datapath loads operands and sets result = 1.
- op_start  out  1  one-cycle pulse launching a datapath operation.
- op_sel  out  1  0 = square, 1 = multiply; valid while op_start = 1 and held through the matching wait state.
- bit_idx  out  $clog2(EXP_W) (min 1)  current exponent bit index.
- running  out  1  high in every state except IDLE and DONE.
- done  out  1  one-cycle pulse on successful completion.
- err  out  1  one-cycle pulse on watchdog expiry or abort.

## Operation
- States: IDLE, LOAD, SQ_START, SQ_WAIT, MUL_START, MUL_WAIT, NEXT, DONE. Outputs are Moore, decoded from the state register only.
- IDLE: go = 1 → LOAD; otherwise stay.
- LOAD: load = 1; bit_idx ← EXP_W−1 → SQ_START.
- SQ_START: op_start = 1, op_sel = 0 → SQ_WAIT.
- SQ_WAIT: op_done = 1 → MUL_START if exp_bit = 1, else NEXT. exp_bit is sampled in the same cycle as op_done.
- MUL_START: op_start = 1, op_sel = 1 → MUL_WAIT.
- MUL_WAIT: op_done = 1 → NEXT.
- NEXT: if bit_idx = 0 → DONE; else bit_idx ← bit_idx−1 → SQ_START.
- DONE: done = 1 → IDLE.
- Watchdog: the counter clears on entry to each wait state and increments every cycle the FSM stays there without op_done. If the counter reaches TIMEOUT with op_done low: err = 1 in the following cycle, state → IDLE. Counter width is $clog2(TIMEOUT+1).
- Abort: abort = 1 in any non-IDLE state → IDLE at the next edge; err pulses for one cycle, registered alongside that transition. Abort has priority over op_done and over watchdog expiry in the same cycle.
- go while not IDLE is ignored. op_done outside the wait states is ignored.

## Timing
- Reset values: state IDLE, bit_idx 0, watchdog 0; load, op_start, op_sel, running, done, err all 0.
- go sampled high at edge 0 → LOAD during cycle 1 → first op_start in cycle 2.
- Per bit with op_done returned in the first wait cycle: 3 cycles for bit = 0, 5 cycles for bit = 1.
- Total operations = EXP_W + popcount(exponent). done is asserted the cycle after the NEXT state for bit_idx 0.
- Reset low mid-run: next cycle is IDLE with all outputs 0. No done or err pulse.

## Structure
- Shared package: state encoding localparams and the op_sel codes OP_SQUARE = 0, OP_MULT = 1, reused by the datapath.
- One sub-module, modexp_watchdog: a TIMEOUT-parametrised counter with clear, enable and expired outputs. The remainder is a single FSM with a bit-index down-counter.

## Test plan
- EXP_W = 4, exponent 4'b1011, op_done returned in the first wait cycle → 7 op_start pulses with op_sel sequence 0,1,0,0,1,0,1; load in cycle 1; done in cycle 20.
- Exponent 4'b0000 → 4 squares, no multiplies, done in cycle 14; exponent 4'b1111 → 8 ops, done in cycle 22.
- TIMEOUT = 8, op_done never returned → err pulses in the cycle after the wait counter reaches 8, FSM back in IDLE, no done pulse.
- abort asserted in MUL_WAIT, with op_done high in the same cycle → IDLE next cycle, single err pulse, no MUL→NEXT progression.
- go held high during a run and op_done pulsed while in SQ_START → no restart and no skipped state; schedule identical to the first test.
- reset driven low during SQ_WAIT for one cycle → all outputs 0 the next cycle; a fresh go afterwards completes normally.
